bnn_argmax_seq: RTL and testbench

Sequential argmax stage that consumes the packed per-class popcount vector produced by the XNOR-popcount stage and emits the winning class index. It captures one vector per valid/ready handshake, then scans one class per clock. The result and its score are held on a valid/ready output until accepted. It closes the classifier datapath: densein → bnorm → xnorpop → bnn_argmax_seq.

---
 rtl/bnn_pkg.sv | 24 ++
 rtl/bnn_argmax_cmp.sv | 44 ++++
 rtl/bnn_argmax_seq.sv | 128 ++++++++++++
 tb/tb_bnn_argmax_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// +----------------------------------------------------------------------------+
// | Package   : bnn_pkg                                                        |
// | Purpose   : Shared sizing constants and argmax FSM state type for the      |
// |             binary classifier datapath.                                    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package bnn_pkg;

    localparam int N_CLASS = 10;
    localparam int CNT_W   = 5;
    // A single class still needs a 1-bit index port.
    localparam int CLS_W   = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

endpackage : bnn_pkg

`default_nettype wire

// File: rtl/bnn_argmax_cmp.sv
// +----------------------------------------------------------------------------+
// | Module    : bnn_argmax_cmp                                                 |
// | Purpose   : One-candidate compare/update step of the argmax (ties keep the |
// |             incumbent). Second-best tracking only with ARGMAX_MARGIN_EN.   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module bnn_argmax_cmp
    import bnn_pkg::*;
(
`ifdef ARGMAX_MARGIN_EN
    input  logic [CNT_W-1:0] second,
    output logic [CNT_W-1:0] second_nxt,
`endif
    input  logic [CNT_W-1:0] candidate,
    input  logic [CNT_W-1:0] best,
    input  logic [CLS_W-1:0] best_idx,
    input  logic [CLS_W-1:0] idx,
    output logic [CNT_W-1:0] best_nxt,
    output logic [CLS_W-1:0] best_idx_nxt
);

    always_comb begin
        best_nxt     = best;
        best_idx_nxt = best_idx;
`ifdef ARGMAX_MARGIN_EN
        second_nxt   = second;
`endif
        // Strict compare: an equal candidate never displaces the lower index.
        if (candidate > best) begin
            best_nxt     = candidate;
            best_idx_nxt = idx;
`ifdef ARGMAX_MARGIN_EN
            second_nxt   = best;
        end else if (candidate > second) begin
            second_nxt   = candidate;
`endif
        end
    end

endmodule : bnn_argmax_cmp

`default_nettype wire

// File: rtl/bnn_argmax_seq.sv
// +----------------------------------------------------------------------------+
// | Module    : bnn_argmax_seq                                                 |
// | Purpose   : Sequential argmax over a packed popcount vector, one class per |
// |             clock; optional best-minus-second margin (ARGMAX_MARGIN_EN).   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module bnn_argmax_seq
    import bnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CLASS*CNT_W-1:0] in_counts,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLS_W-1:0]         out_class,
`ifdef ARGMAX_MARGIN_EN
    output logic [CNT_W-1:0]         out_margin,
`endif
    output logic [CNT_W-1:0]         out_score
);

    localparam logic [CLS_W-1:0] C_LAST_IDX = CLS_W'(N_CLASS - 1);
    localparam logic [CLS_W-1:0] C_ONE_IDX  = CLS_W'(1);

    argmax_state_t            state_q, state_d;
    logic [N_CLASS*CNT_W-1:0] cap_q, cap_d;
    logic [CLS_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         best_q, best_d;
    logic [CLS_W-1:0]         best_idx_q, best_idx_d;
    logic [CNT_W-1:0]         w_candidate;
    logic [CNT_W-1:0]         w_best_nxt;
    logic [CLS_W-1:0]         w_best_idx_nxt;
`ifdef ARGMAX_MARGIN_EN
    logic [CNT_W-1:0]         second_q, second_d;
    logic [CNT_W-1:0]         w_second_nxt;
`endif

    assign w_candidate = cap_q[idx_q*CNT_W +: CNT_W];

    bnn_argmax_cmp u_cmp (
`ifdef ARGMAX_MARGIN_EN
        .second       (second_q),
        .second_nxt   (w_second_nxt),
`endif
        .candidate    (w_candidate),
        .best         (best_q),
        .best_idx     (best_idx_q),
        .idx          (idx_q),
        .best_nxt     (w_best_nxt),
        .best_idx_nxt (w_best_idx_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cap_q      <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= second_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (N_CLASS == 1) ? DONE : SCAN;
            SCAN:    if (idx_q == C_LAST_IDX) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: seed from class 0 on capture, fold one class per SCAN edge.
    always_comb begin
        cap_d      = cap_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
`ifdef ARGMAX_MARGIN_EN
        second_d   = second_q;
`endif
        if (state_q == IDLE && in_valid) begin
            cap_d      = in_counts;
            idx_d      = C_ONE_IDX;
            best_d     = in_counts[CNT_W-1:0];
            best_idx_d = '0;
`ifdef ARGMAX_MARGIN_EN
            second_d   = '0;
`endif
        end else if (state_q == SCAN) begin
            idx_d      = idx_q + C_ONE_IDX;
            best_d     = w_best_nxt;
            best_idx_d = w_best_idx_nxt;
`ifdef ARGMAX_MARGIN_EN
            second_d   = w_second_nxt;
`endif
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        out_class  = best_idx_q;
        out_score  = best_q;
`ifdef ARGMAX_MARGIN_EN
        out_margin = best_q - second_q;
`endif
    end

endmodule : bnn_argmax_seq

`default_nettype wire

// File: tb/tb_bnn_argmax_seq.sv
// +----------------------------------------------------------------------------+
// | Module    : tb_bnn_argmax_seq                                              |
// | Purpose   : Self-checking bench for bnn_argmax_seq against a plain argmax  |
// |             reference; margin checks apply when ARGMAX_MARGIN_EN is set.   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bnn_argmax_seq;
    import bnn_pkg::*;

    localparam int VW = N_CLASS * CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [VW-1:0]    in_counts;
    logic             out_valid;
    logic             out_ready;
    logic [CLS_W-1:0] out_class;
    logic [CNT_W-1:0] out_score;
`ifdef ARGMAX_MARGIN_EN
    logic [CNT_W-1:0] out_margin;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bnn_argmax_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_counts (in_counts),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
`ifdef ARGMAX_MARGIN_EN
        .out_margin(out_margin),
`endif
        .out_score (out_score)
    );

    always #5 clk = ~clk;

    // Reference: winner is the first index holding the maximum; margin is the
    // maximum minus the largest count among all other classes.
    function automatic void ref_argmax(input logic [VW-1:0] v, output int cls,
                                       output int score, output int margin);
        int c;
        int other;
        score = -1;
        cls   = 0;
        for (int i = 0; i < N_CLASS; i++) begin
            c = int'(v[i*CNT_W +: CNT_W]);
            if (c > score) begin
                score = c;
                cls   = i;
            end
        end
        other = 0;
        for (int i = 0; i < N_CLASS; i++) begin
            c = int'(v[i*CNT_W +: CNT_W]);
            if (i != cls && c > other) other = c;
        end
        margin = score - other;
    endfunction

    function automatic logic [VW-1:0] pack(input int c [N_CLASS]);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < N_CLASS; i++) v[i*CNT_W +: CNT_W] = CNT_W'(c[i]);
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec(input int maxv);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < N_CLASS; i++) v[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, maxv));
        return v;
    endfunction

    // Presents one vector (in_ready must be high), scrambles in_counts after
    // acceptance and counts edges until out_valid, bounded.
    task automatic run_vec(input logic [VW-1:0] v, output int lat);
        in_valid  = 1'b1;
        in_counts = v;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_counts = rand_vec(31);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_counts = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_class !== '0) begin n_fail++; $display("FAIL reset_class: got %0d expected 0", out_class); end
        n_tests++; if (out_score !== '0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", out_score); end
`ifdef ARGMAX_MARGIN_EN
        n_tests++; if (out_margin !== '0) begin n_fail++; $display("FAIL reset_margin: got %0d expected 0", out_margin); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int c [N_CLASS];
        logic [VW-1:0] v;
        int lat, ecls, escore, emargin;
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            case (t)
                0:       c = '{3, 7, 2, 9, 1, 0, 9, 4, 5, 6};
                1:       c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
                default: c = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 31};
            endcase
            v = pack(c);
            ref_argmax(v, ecls, escore, emargin);
            run_vec(v, lat);
            n_tests++; if (lat !== N_CLASS - 1) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", t, lat, N_CLASS - 1); end
            n_tests++; if (out_class !== CLS_W'(ecls)) begin n_fail++; $display("FAIL dir%0d_class: got %0d expected %0d", t, out_class, ecls); end
            n_tests++; if (out_score !== CNT_W'(escore)) begin n_fail++; $display("FAIL dir%0d_score: got %0d expected %0d", t, out_score, escore); end
`ifdef ARGMAX_MARGIN_EN
            n_tests++; if (out_margin !== CNT_W'(emargin)) begin n_fail++; $display("FAIL dir%0d_margin: got %0d expected %0d", t, out_margin, emargin); end
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] v;
        int lat, ecls, escore, emargin;
        out_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            v = rand_vec(($urandom_range(0, 1) == 1) ? 3 : 31);
            ref_argmax(v, ecls, escore, emargin);
            run_vec(v, lat);
            n_tests++; if (lat !== N_CLASS - 1 || out_class !== CLS_W'(ecls) || out_score !== CNT_W'(escore)) begin
                n_fail++;
                $display("FAIL rand%0d_result: got class %0d score %0d lat %0d expected class %0d score %0d lat %0d",
                         t, out_class, out_score, lat, ecls, escore, N_CLASS - 1);
            end
`ifdef ARGMAX_MARGIN_EN
            n_tests++; if (out_margin !== CNT_W'(emargin)) begin n_fail++; $display("FAIL rand%0d_margin: got %0d expected %0d", t, out_margin, emargin); end
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int c [N_CLASS];
        logic [VW-1:0] v;
        int lat, ecls, escore, emargin;
        bit bad;
        out_ready = 1'b0;
        v = rand_vec(31);
        ref_argmax(v, ecls, escore, emargin);
        run_vec(v, lat);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== CLS_W'(ecls) || out_score !== CNT_W'(escore)) bad = 1'b1;
`ifdef ARGMAX_MARGIN_EN
            if (out_margin !== CNT_W'(emargin)) bad = 1'b1;
`endif
            @(posedge clk); #1;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL bp_hold: got class %0d score %0d valid %b ready %b expected class %0d score %0d valid 1 ready 0",
                                                    out_class, out_score, out_valid, in_ready, ecls, escore); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got ready %b valid %b expected ready 1 valid 0", in_ready, out_valid); end
        c = '{0, 0, 0, 0, 0, 12, 0, 0, 0, 0};
        run_vec(pack(c), lat);
        n_tests++; if (out_class !== CLS_W'(5) || out_score !== CNT_W'(12)) begin n_fail++; $display("FAIL bp_second: got class %0d score %0d expected class 5 score 12", out_class, out_score); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midscan();
        logic [VW-1:0] v;
        int lat, ecls, escore, emargin;
        bit seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_counts = rand_vec(31);
        in_counts[CNT_W-1:0] = CNT_W'(20);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== '0 || out_score !== '0) begin
            n_fail++;
            $display("FAIL midscan_reset: got ready %b valid %b class %0d score %0d expected 1 0 0 0", in_ready, out_valid, out_class, out_score);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL midscan_no_valid: got out_valid pulse expected none"); end
        v = rand_vec(31);
        ref_argmax(v, ecls, escore, emargin);
        run_vec(v, lat);
        n_tests++; if (lat !== N_CLASS - 1 || out_class !== CLS_W'(ecls) || out_score !== CNT_W'(escore)) begin
            n_fail++;
            $display("FAIL midscan_next: got class %0d score %0d lat %0d expected class %0d score %0d lat %0d",
                     out_class, out_score, lat, ecls, escore, N_CLASS - 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] pending [$];
        int accept_cyc [$];
        logic [VW-1:0] pre_counts, v;
        logic pre_ready;
        int ecls, escore, emargin, results, cyc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_counts = rand_vec(31);
        results = 0;
        cyc = 0;
        while (results < 5 && cyc < 100) begin
            pre_ready  = in_ready;
            pre_counts = in_counts;
            @(posedge clk); #1;
            cyc++;
            if (pre_ready) begin
                pending.push_back(pre_counts);
                accept_cyc.push_back(cyc);
            end
            if (out_valid) begin
                results++;
                if (pending.size() > 0) begin
                    v = pending.pop_front();
                    ref_argmax(v, ecls, escore, emargin);
                    n_tests++; if (out_class !== CLS_W'(ecls) || out_score !== CNT_W'(escore)) begin
                        n_fail++;
                        $display("FAIL b2b%0d_result: got class %0d score %0d expected class %0d score %0d", results, out_class, out_score, ecls, escore);
                    end
`ifdef ARGMAX_MARGIN_EN
                    n_tests++; if (out_margin !== CNT_W'(emargin)) begin n_fail++; $display("FAIL b2b%0d_margin: got %0d expected %0d", results, out_margin, emargin); end
`endif
                end else begin
                    n_tests++; n_fail++;
                    $display("FAIL b2b%0d_orphan: got out_valid expected no result pending", results);
                end
            end
            in_counts = rand_vec(31);
        end
        in_valid = 1'b0;
        n_tests++; if (results !== 5) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 5", results); end
        for (int i = 1; i < accept_cyc.size(); i++) begin
            n_tests++; if (accept_cyc[i] - accept_cyc[i-1] !== N_CLASS + 1) begin
                n_fail++;
                $display("FAIL b2b_interval%0d: got %0d cycles expected %0d", i, accept_cyc[i] - accept_cyc[i-1], N_CLASS + 1);
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midscan();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bnn_argmax_seq

`default_nettype wire
